// File: rtl/dlx_ifid_skid_reg.sv
// Fetch-to-decode skid register (main + skid entry); optional stall counter under IFID_PERF_CNT_EN.
// Latency: out_valid one cycle after in_fire; out_pc/out_instr driven straight from the main regs.
// Backpressure: in_ready is decoded from the state flop only, so decode stalls never reach fetch combinationally.
module dlx_ifid_skid_reg #(
    parameter int AW = 32,
    parameter int IW = 32,
    parameter logic [IW-1:0] NOP_INSTR = '0
`ifdef IFID_PERF_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_pc,
    input  logic [IW-1:0] in_instr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_pc,
    output logic [IW-1:0] out_instr
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] main_pc, main_pc_nxt, skid_pc, skid_pc_nxt;
    logic [IW-1:0] main_instr, main_instr_nxt, skid_instr, skid_instr_nxt;
    logic          in_fire, out_fire;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_pc    = main_pc;
    assign out_instr = main_instr;

    always_comb begin
        state_nxt      = state;
        main_pc_nxt    = main_pc;
        main_instr_nxt = main_instr;
        skid_pc_nxt    = skid_pc;
        skid_instr_nxt = skid_instr;
        if (flush) begin
            // Redirect: both entries die, including any word fetched this cycle.
            state_nxt      = EMPTY;
            main_pc_nxt    = '0;
            main_instr_nxt = NOP_INSTR;
            skid_pc_nxt    = '0;
            skid_instr_nxt = NOP_INSTR;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_pc_nxt    = in_pc;
                        main_instr_nxt = in_instr;
                        state_nxt      = ONE;
                    end
                end
                ONE: begin
                    case ({in_fire, out_fire})
                        2'b11: begin
                            main_pc_nxt    = in_pc;
                            main_instr_nxt = in_instr;
                        end
                        2'b10: begin
                            skid_pc_nxt    = in_pc;
                            skid_instr_nxt = in_instr;
                            state_nxt      = TWO;
                        end
                        2'b01: begin
                            main_pc_nxt    = '0;
                            main_instr_nxt = NOP_INSTR;
                            state_nxt      = EMPTY;
                        end
                        default: ;
                    endcase
                end
                TWO: begin
                    if (out_fire) begin
                        main_pc_nxt    = skid_pc;
                        main_instr_nxt = skid_instr;
                        state_nxt      = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= EMPTY;
            main_pc    <= '0;
            main_instr <= NOP_INSTR;
            skid_pc    <= '0;
            skid_instr <= NOP_INSTR;
        end else begin
            state      <= state_nxt;
            main_pc    <= main_pc_nxt;
            main_instr <= main_instr_nxt;
            skid_pc    <= skid_pc_nxt;
            skid_instr <= skid_instr_nxt;
        end
    end

`ifdef IFID_PERF_CNT_EN
    // Counts fetch-stall cycles; flush leaves it alone, only RESET clears it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
